// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encoding, register offsets, access sizes and STATUS bit positions
package uart_tx_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    function automatic logic [3:0] sat15(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[3:0];
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous TX FIFO; a push while full is accepted only if a pop happens the same cycle
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_din  : write request and byte
//   i_pop          : remove head (ignored when empty)
//   o_head         : current head entry, read straight from the storage flops
//   o_full, o_empty, o_count : occupancy
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_count;
    logic w_push, w_pop;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rp];
    assign w_pop   = i_pop & !o_empty;
    assign w_push  = i_push & (!o_full | w_pop);
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's data-memory port
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_we, i_a, i_wd, i_be : store strobe, byte address, store data, access size
//   o_rd, o_hit    : combinational read data (0 outside window) and window hit
//   o_tx           : serial line, idle high
//   o_irq          : TX-done interrupt, present only when UART_TX_IRQ_EN is defined
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [31:0] i_a,
    input  logic [31:0] i_wd,
    input  logic [1:0]  i_be,
    output logic [31:0] o_rd,
    output logic        o_hit,
    output logic        o_tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t r_state;
    logic [15:0] r_div, r_fdiv, r_baud;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic r_tx, r_ovf;
    logic [7:0] w_head;
    logic w_full, w_empty;
    logic [CW-1:0] w_count;
    logic [1:0] w_off;
    logic w_wr, w_push, w_pop, w_bit_end;
    logic [15:0] w_div_new;
    logic [31:0] w_status, w_ctrl;
    logic w_unused;
    assign w_unused  = ^{i_wd[31:16], i_a[1:0]};
    assign o_hit     = (i_a[31:4] == BASE_ADDR[31:4]);
    assign w_off     = i_a[3:2];
    assign w_wr      = i_we & o_hit;
    assign w_push    = w_wr & (w_off == OFF_TXDATA);
    assign w_bit_end = (r_baud == 16'd0);
    assign w_pop     = !w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
    assign w_div_new = (i_be == SZ_B) ? {r_div[15:8], i_wd[7:0]} : i_wd[15:0];
    assign o_tx      = r_tx;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_din   (i_wd[7:0]),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    always_comb begin
        w_status           = '0;
        w_status[ST_BUSY]  = (r_state != IDLE);
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_OVF]   = r_ovf;
        w_status[7:4]      = sat15(32'(w_count));
    end
    always_comb begin
        o_rd = !o_hit                  ? 32'd0 :
               (w_off == OFF_STATUS)   ? w_status :
               (w_off == OFF_BAUDDIV)  ? {16'd0, r_div} :
               (w_off == OFF_CTRL)     ? w_ctrl : 32'd0;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div   <= DEFAULT_DIV;
            r_fdiv  <= DEFAULT_DIV;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_tx    <= 1'b1;
        end else begin
            if (w_wr & (w_off == OFF_BAUDDIV)) r_div <= (w_div_new == 16'd0) ? 16'd1 : w_div_new;
            // overflow set takes priority over a same-cycle clear
            if (w_push & w_full & !w_pop) r_ovf <= 1'b1;
            else if (w_wr & (w_off == OFF_STATUS) & i_wd[ST_OVF]) r_ovf <= 1'b0;
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_state <= START;
                    r_sh    <= w_head;
                    r_baud  <= r_div;
                    r_fdiv  <= r_div;
                    r_tx    <= 1'b0;
                end
                START: if (w_bit_end) begin
                    r_state <= DATA;
                    r_baud  <= r_fdiv;
                    r_bit   <= '0;
                    r_tx    <= r_sh[0];
                end else r_baud <= r_baud - 1'b1;
                DATA: if (w_bit_end) begin
                    r_baud <= r_fdiv;
                    if (r_bit == 3'd7) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                        r_tx  <= r_sh[r_bit + 3'd1];
                    end
                end else r_baud <= r_baud - 1'b1;
                STOP: if (w_bit_end) begin
                    // next byte starts immediately so back-to-back frames have no idle gap
                    if (!w_empty) begin
                        r_state <= START;
                        r_sh    <= w_head;
                        r_baud  <= r_div;
                        r_fdiv  <= r_div;
                        r_tx    <= 1'b0;
                    end else r_state <= IDLE;
                end else r_baud <= r_baud - 1'b1;
            endcase
        end
    end
`ifdef UART_TX_IRQ_EN
    logic r_ien, r_irq;
    assign w_ctrl = {31'd0, r_ien};
    assign o_irq  = r_irq;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ien <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr & (w_off == OFF_CTRL)) r_ien <= i_wd[0];
            r_irq <= r_ien & w_empty & (r_state == IDLE);
        end
    end
`else
    assign w_ctrl = 32'd0;
`endif
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
    localparam logic [31:0] A_TX = 32'h2000, A_ST = 32'h2004, A_BD = 32'h2008, A_CT = 32'h200C;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
    logic clk = 0, reset = 1, we = 0;
    logic [31:0] a = 0, wd = 0, rd;
    logic [1:0] be = 0;
    logic hit, tx;
`ifdef UART_TX_IRQ_EN
    logic irq;
`endif
    int n_chk = 0, n_fail = 0;
    logic [31:0] d;
    always #5 clk = ~clk;
    mmio_uart_tx dut (
        .i_clk(clk), .i_reset(reset), .i_we(we), .i_a(a), .i_wd(wd), .i_be(be),
        .o_rd(rd), .o_hit(hit), .o_tx(tx)
`ifdef UART_TX_IRQ_EN
        , .o_irq(irq)
`endif
    );
    function automatic logic fbit(input logic [7:0] b, input int k, input int bt);
        int p;
        p = k / bt;
        return (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
    endfunction
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        we = 1; a = addr; wd = data; be = sz;
        step();
        we = 0;
    endtask
    task automatic rdreg(input logic [31:0] addr, output logic [31:0] v);
        we = 0; a = addr;
        #1 v = rd;
    endtask
    task automatic test_reset();
        reset = 1;
        repeat (2) step();
        reset = 0;
        n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        rdreg(A_ST, d);
        n_chk++; if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_hit: got %b want 1", hit); end
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h want 00000004", d); end
        rdreg(A_BD, d);
        n_chk++; if (d !== 32'd433) begin n_fail++; $display("FAIL reset_bauddiv: got %0d want 433", d); end
        rdreg(A_CT, d);
        n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
    endtask
    task automatic test_single_byte();
        wr(A_BD, 32'd3, SW);
        wr(A_TX, 32'hA5, SB);
        n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_tx: got %b want 1", tx); end
        step();
        for (int k = 0; k < 40; k++) begin
            n_chk++; if (tx !== fbit(8'hA5, k, 4)) begin n_fail++; $display("FAIL single_tx k=%0d: got %b want %b", k, tx, fbit(8'hA5, k, 4)); end
            if (k == 20) begin
                rdreg(A_ST, d);
                n_chk++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid: got %b want 1", d[0]); end
            end
            step();
        end
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL single_status_end: got %h want 00000004", d); end
        n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_idle: got %b want 1", tx); end
    endtask
    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        bytes[0] = 8'h5A; bytes[1] = 8'hFF; bytes[2] = 8'h00; bytes[3] = 8'h81;
        for (int i = 0; i < 4; i++) wr(A_TX, {24'd0, bytes[i]}, SB);
        rdreg(A_ST, d);
        n_chk++; if (d[7:4] !== 4'd3 || d[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_count3: got %h want count 3, not empty", d); end
        for (int k = 2; k < 160; k++) begin
            n_chk++; if (tx !== fbit(bytes[k/40], k % 40, 4)) begin n_fail++; $display("FAIL b2b_tx k=%0d: got %b want %b", k, tx, fbit(bytes[k/40], k % 40, 4)); end
            if (k == 50) begin
                rdreg(A_ST, d);
                n_chk++; if (d[7:4] !== 4'd2) begin n_fail++; $display("FAIL b2b_count2: got %0d want 2", d[7:4]); end
            end
            step();
        end
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL b2b_status_end: got %h want 00000004", d); end
    endtask
    task automatic test_overflow();
        int n;
        for (int i = 0; i < 9; i++) wr(A_TX, i, SB);
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h83) begin n_fail++; $display("FAIL ovf_full: got %h want 00000083", d); end
        wr(A_TX, 32'h99, SB);
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h8B) begin n_fail++; $display("FAIL ovf_set: got %h want 0000008b", d); end
        wr(A_ST, 32'h0, SW);
        rdreg(A_ST, d);
        n_chk++; if (d[3] !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b want 1", d[3]); end
        wr(A_ST, 32'h8, SB);
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h83) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000083", d); end
        n = 0;
        rdreg(A_ST, d);
        while (d[0] === 1'b1 && n < 1000) begin
            step();
            n++;
            rdreg(A_ST, d);
        end
        n_chk++; if (n !== 350) begin n_fail++; $display("FAIL ovf_drain_cycles: got %0d want 350", n); end
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL ovf_drained: got %h want 00000004", d); end
    endtask
    task automatic test_bauddiv();
        wr(A_BD, 32'hFFFF_FF12, SB);
        rdreg(A_BD, d);
        n_chk++; if (d !== 32'h12) begin n_fail++; $display("FAIL bd_byte: got %h want 00000012", d); end
        wr(A_BD, 32'hABCD_0000, SH);
        rdreg(A_BD, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL bd_zero: got %h want 00000001", d); end
        wr(A_BD, 32'h1234, SH);
        wr(A_BD, 32'h0, SB);
        rdreg(A_BD, d);
        n_chk++; if (d !== 32'h1200) begin n_fail++; $display("FAIL bd_byte_keep_hi: got %h want 00001200", d); end
        wr(A_BD, 32'd3, SW);
        wr(A_TX, 32'h0F, SB);
        step();
        for (int k = 0; k < 40; k++) begin
            we = (k == 10); a = A_BD; wd = 32'd7; be = SW;
            n_chk++; if (tx !== fbit(8'h0F, k, 4)) begin n_fail++; $display("FAIL bd_mid_tx k=%0d: got %b want %b", k, tx, fbit(8'h0F, k, 4)); end
            step();
        end
        we = 0;
        rdreg(A_BD, d);
        n_chk++; if (d !== 32'd7) begin n_fail++; $display("FAIL bd_mid_value: got %0d want 7", d); end
        rdreg(A_ST, d);
        n_chk++; if (d[0] !== 1'b0) begin n_fail++; $display("FAIL bd_mid_idle: got %b want 0", d[0]); end
        wr(A_TX, 32'hC3, SB);
        step();
        for (int k = 0; k < 80; k++) begin
            n_chk++; if (tx !== fbit(8'hC3, k, 8)) begin n_fail++; $display("FAIL bd_new_tx k=%0d: got %b want %b", k, tx, fbit(8'hC3, k, 8)); end
            step();
        end
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL bd_new_end: got %h want 00000004", d); end
    endtask
    task automatic test_reset_midframe();
        int lows;
        wr(A_BD, 32'd3, SW);
        wr(A_TX, 32'hEF, SB);
        wr(A_TX, 32'h55, SB);
        repeat (21) step();
        n_chk++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_bit4: got %b want 0", tx); end
        reset = 1;
        step();
        n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
        reset = 0;
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL rst_status: got %h want 00000004", d); end
        rdreg(A_BD, d);
        n_chk++; if (d !== 32'd433) begin n_fail++; $display("FAIL rst_bauddiv: got %0d want 433", d); end
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            if (tx !== 1'b1) lows++;
            step();
        end
        n_chk++; if (lows !== 0) begin n_fail++; $display("FAIL rst_residual: got %0d low cycles want 0", lows); end
    endtask
    task automatic test_outside();
        a = 32'h0000_3008; we = 0;
        #1;
        n_chk++; if (hit !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL out_read: got hit=%b rd=%h want 0 0", hit, rd); end
        a = 32'h0000_1FFC;
        #1;
        n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL out_below: got %b want 0", hit); end
        wr(32'h0000_3008, 32'd5, SW);
        wr(32'h0000_2010, 32'h99, SB);
        repeat (5) step();
        n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL out_tx: got %b want 1", tx); end
        rdreg(A_ST, d);
        n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL out_status: got %h want 00000004", d); end
        rdreg(A_BD, d);
        n_chk++; if (d !== 32'd433) begin n_fail++; $display("FAIL out_bauddiv: got %0d want 433", d); end
    endtask
`ifdef UART_TX_IRQ_EN
    task automatic test_irq();
        wr(A_BD, 32'd3, SW);
        wr(A_CT, 32'h1, SB);
        step();
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_idle: got %b want 1", irq); end
        rdreg(A_CT, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_ctrl: got %h want 00000001", d); end
        wr(A_TX, 32'h01, SB);
        step();
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_busy: got %b want 0", irq); end
        repeat (40) step();
        rdreg(A_ST, d);
        n_chk++; if (d[0] !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_at_idle: got busy=%b irq=%b want 0 0", d[0], irq); end
        step();
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_idle: got %b want 1", irq); end
    endtask
`endif
    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_bauddiv();
        test_reset_midframe();
        test_outside();
`ifdef UART_TX_IRQ_EN
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
